gpio_input_filter: RTL and testbench
====================================

# gpio_input_filter

Per-bit input conditioning stage that sits directly upstream of the GPIO data-input register. It synchronises asynchronous pad inputs into the bus clock domain, suppresses glitches with a programmable stability counter, and emits one-cycle rise/fall pulses. The GPIO core's DATA_I sampling and edge-interrupt logic consume these pulses instead of raw pad levels.

## Interface
- NUM_BITS, 8, number of GPIO lines.
- CNT_WIDTH, 16, width of the stability counter and threshold.
- SYNC_STAGES, 2, synchroniser depth; legal range 2-4.

- wb_clk_i  in  1  system/bus clock; every flop in the block is on this clock.
- wb_rst_i  in  1  reset, synchronous and active-high.
- pin_i  in  NUM_BITS  raw asynchronous pad inputs.
- filt_en_i  in  NUM_BITS  per-bit filter enable; 0 = bypass the counter.
- threshold_i  in  CNT_WIDTH  required consecutive stable cycles; quasi-static.
- data_o  out  NUM_BITS  filtered, synchronised level.
- rise_o  out  NUM_BITS  one-cycle pulse on a 0->1 transition of data_o.
- fall_o  out  NUM_BITS  one-cycle pulse on a 1->0 transition of data_o.
- change_o  out  1  OR of rise_o and fall_o over all bits.

## Operation
- Per bit: an SYNC_STAGES-flop synchroniser produces s. A filtered level q drives data_o. A counter cnt has width CNT_WIDTH.
- Effective threshold T = max(threshold_i, 1). A threshold of 0 behaves as 1.
- Filter enabled (filt_en_i[i]=1), evaluated each clock:
  - s == q: cnt <= 0.
  - s != q and cnt >= T-1: q <= s, cnt <= 0.
  - otherwise: cnt <= cnt+1.
- Filter disabled: q <= s every cycle, and cnt <= 0.
- A glitch that returns s to q before the threshold is reached resets cnt to 0. q does not change and no pulse is generated.
- cnt never exceeds T-1, so no overflow is possible.
- threshold_i changes take effect on the next clock. If cnt already satisfies cnt >= new T-1 and s != q, q updates on that clock.
- rise_o/fall_o are registered from the next-state of q versus the current q. They are asserted in the same cycle that data_o shows the new level, for exactly one cycle.
- Toggling filt_en_i mid-count:
  - 1->0: q follows s on the next clock and the count is discarded.
  - 0->1: counting starts from 0.
- Bits are fully independent. Simultaneous transitions on several bits each pulse, and change_o is a single cycle.

## Timing
- Reset values: synchroniser flops 0, q/data_o 0, cnt 0, rise_o 0, fall_o 0, change_o 0.
- After reset deassertion, a pin held high produces a normal rise_o pulse after the latency below. Reset itself never generates a pulse.
- Reset asserted mid-count clears everything on that clock edge.
- Latency is counted from the first clock edge that samples the new pin level to data_o valid:
  - Bypass: SYNC_STAGES+1 edges.
  - Filtered: SYNC_STAGES+T edges, provided the pin is held stable throughout.
- Minimum pulse width that passes the filter: T clock cycles (as seen after synchronisation). Shorter pulses are rejected.
- No handshake. Outputs update every clock and the consumer samples data_o/rise_o/fall_o directly.

## Configuration
- Macro: GPIO_FILTER_EDGE_EN.
- Defined: rise_o, fall_o and change_o are generated as described above.
- Undefined: the edge-pulse registers are not built. rise_o, fall_o and change_o are tied to 0, and data_o behaviour is unchanged. The GPIO core must then perform its own edge detection.

## Test plan
- Reset, then pin_i=8'hFF with filt_en_i=0 (SYNC_STAGES=2): data_o=8'hFF exactly 3 edges after sampling; rise_o=8'hFF for one cycle coincident with that change; change_o=1 for one cycle.
- filt_en_i=8'h01, threshold_i=4, pin_i[0] high for 3 cycles then low: data_o[0] stays 0; rise_o[0] never asserts.
- Same configuration, pin_i[0] high for 4+ cycles: data_o[0]=1 at edge 2+4=6; then pin_i[0] low for 4 cycles gives fall_o[0] pulse and data_o[0]=0.
- threshold_i=0 with filt_en_i=8'hFF: behaviour identical to bypass (latency 3) on pattern 8'hA5.
- Assert wb_rst_i while bit 0's counter is at 2 of 4: data_o=0, no pulses. Release with the pin still high: rise_o[0] after 6 edges.
- Build without GPIO_FILTER_EDGE_EN and toggle pin_i=8'h55/8'hAA: data_o tracks as before; rise_o, fall_o and change_o remain 0 throughout.

Source files
------------

// File: rtl/gpio_input_filter.sv
`default_nettype none
// ============================================================================
// Module   : gpio_input_filter
// Purpose  : Per-bit GPIO input conditioning. Each pad input is
//            synchronised into the wb_clk_i domain and then passed through a
//            programmable stability filter. The block also produces
//            one-cycle rise and fall pulses on the filtered level.
// Ports    : wb_clk_i    - bus clock; every flop in the block uses it
//            wb_rst_i    - synchronous, active-high reset
//            pin_i       - raw asynchronous pad inputs
//            filt_en_i   - per-bit filter enable (0 = bypass the counter)
//            threshold_i - number of consecutive stable cycles required
//                          (quasi-static; 0 behaves as 1)
//            data_o      - filtered, synchronised level
//            rise_o      - one-cycle pulse on a 0->1 change of data_o
//            fall_o      - one-cycle pulse on a 1->0 change of data_o
//            change_o    - OR of rise_o and fall_o over all bits
// Config   : GPIO_FILTER_EDGE_EN - when defined, the edge-pulse registers
//            are built. When undefined, rise_o, fall_o and change_o are
//            tied to 0.
//            SYNC_STAGES must lie in the range 2-4.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_input_filter #(
  parameter int NUM_BITS    = 8,
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [NUM_BITS-1:0]  pin_i,
  input  logic [NUM_BITS-1:0]  filt_en_i,
  input  logic [CNT_WIDTH-1:0] threshold_i,
  output logic [NUM_BITS-1:0]  data_o,
  output logic [NUM_BITS-1:0]  rise_o,
  output logic [NUM_BITS-1:0]  fall_o,
  output logic                 change_o
);

  // Synchroniser chain. Stage 0 samples the pads, and the last stage is the
  // synchronised level "s" that the filter works on.
  logic [SYNC_STAGES-1:0][NUM_BITS-1:0] sync_q;
  logic [SYNC_STAGES-1:0][NUM_BITS-1:0] sync_d;
  logic [NUM_BITS-1:0]                  s;

  // Filtered level, and the next-state value that the edge logic compares
  // against it.
  logic [NUM_BITS-1:0]                  data_q;
  logic [NUM_BITS-1:0]                  data_d;

  // This is the effective threshold minus one. A zero threshold is treated
  // as one, so the comparison below is always against T-1 >= 0.
  logic [CNT_WIDTH-1:0]                 thr_m1;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
  end

  assign s      = sync_q[SYNC_STAGES-1];
  assign thr_m1 = (threshold_i == '0) ? '0 : threshold_i - 1'b1;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync_q <= '0;
      data_q <= '0;
    end else begin
      sync_q <= sync_d;
      data_q <= data_d;
    end
  end

  // Per-bit stability counter. The counter tracks how long s has disagreed
  // with q. Any agreement, including a glitch returning to q, restarts the
  // count. Because the commit test is "cnt >= T-1", a threshold lowered
  // mid-count commits on the next clock. The counter never runs past T-1.
  for (genvar i = 0; i < NUM_BITS; i++) begin : g_bit
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 q_d;

    always_comb begin
      cnt_d = '0;
      q_d   = data_q[i];
      if (!filt_en_i[i]) begin
        q_d = s[i];
      end else if (s[i] != data_q[i]) begin
        if (cnt_q >= thr_m1) begin
          q_d = s[i];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign data_d[i] = q_d;
  end

  assign data_o = data_q;

`ifdef GPIO_FILTER_EDGE_EN
  // Pulses are registered from next-state versus current q, so each pulse
  // appears in the same cycle that data_o shows the new level.
  logic [NUM_BITS-1:0] rise_q;
  logic [NUM_BITS-1:0] rise_d;
  logic [NUM_BITS-1:0] fall_q;
  logic [NUM_BITS-1:0] fall_d;
  logic                change_q;
  logic                change_d;

  always_comb begin
    rise_d   = data_d & ~data_q;
    fall_d   = ~data_d & data_q;
    change_d = |(rise_d | fall_d);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rise_q   <= '0;
      fall_q   <= '0;
      change_q <= 1'b0;
    end else begin
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      change_q <= change_d;
    end
  end

  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign change_o = change_q;
`else
  assign rise_o   = '0;
  assign fall_o   = '0;
  assign change_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gpio_input_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_input_filter
// Purpose  : Self-checking bench for gpio_input_filter. Each scenario pushes
//            the expected outputs for an edge onto a scoreboard queue as
//            stimulus is applied, then pops and compares them after the edge.
//            Edge-pulse expectations follow GPIO_FILTER_EDGE_EN: when the
//            macro is undefined, all pulse outputs are expected to be zero.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_input_filter;

`ifdef GPIO_FILTER_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [7:0]  pin;
  logic [7:0]  filt_en;
  logic [15:0] thr;
  logic [7:0]  data_o;
  logic [7:0]  rise_o;
  logic [7:0]  fall_o;
  logic        change_o;

  int checks   = 0;
  int failures = 0;

  // The expected vector is packed as {data, rise, fall, change}.
  logic [24:0] sb[$];
  logic [24:0] exp_v;
  logic [24:0] obs_v;

  gpio_input_filter #(
    .NUM_BITS    (8),
    .CNT_WIDTH   (16),
    .SYNC_STAGES (2)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .pin_i       (pin),
    .filt_en_i   (filt_en),
    .threshold_i (thr),
    .data_o      (data_o),
    .rise_o      (rise_o),
    .fall_o      (fall_o),
    .change_o    (change_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [24:0] mk(input logic [7:0] d, input logic [7:0] r,
                                     input logic [7:0] f);
    logic [7:0] rr;
    logic [7:0] ff;
    rr = EDGE_EN ? r : 8'h00;
    ff = EDGE_EN ? f : 8'h00;
    return {d, rr, ff, |(rr | ff)};
  endfunction

  // Reset is applied with the pins low. Stimulus applied after this returns
  // is sampled first by the next clock edge (edge 1).
  task automatic do_reset(input logic [7:0] fe, input logic [15:0] th);
    rst     = 1'b1;
    pin     = 8'h00;
    filt_en = fe;
    thr     = th;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pin = 8'hFF; filt_en = 8'h00; thr = 16'd0;
    for (int e = 1; e <= 3; e++) begin
      sb.push_back(mk(8'h00, 8'h00, 8'h00));
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      obs_v = {data_o, rise_o, fall_o, change_o};
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL reset e=%0d got d=%h r=%h f=%h c=%b want d=%h r=%h f=%h c=%b",
                 e, obs_v[24:17], obs_v[16:9], obs_v[8:1], obs_v[0],
                 exp_v[24:17], exp_v[16:9], exp_v[8:1], exp_v[0]);
      end
    end
  endtask

  task automatic test_bypass();
    do_reset(8'h00, 16'd0);
    pin = 8'hFF;
    for (int e = 1; e <= 6; e++) begin
      sb.push_back(mk((e >= 3) ? 8'hFF : 8'h00, (e == 3) ? 8'hFF : 8'h00, 8'h00));
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      obs_v = {data_o, rise_o, fall_o, change_o};
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL bypass e=%0d got d=%h r=%h f=%h c=%b want d=%h r=%h f=%h c=%b",
                 e, obs_v[24:17], obs_v[16:9], obs_v[8:1], obs_v[0],
                 exp_v[24:17], exp_v[16:9], exp_v[8:1], exp_v[0]);
      end
    end
  endtask

  // A 3-cycle pulse against T=4 must be swallowed.
  task automatic test_filter_reject();
    do_reset(8'h01, 16'd4);
    pin = 8'h01;
    for (int e = 1; e <= 10; e++) begin
      sb.push_back(mk(8'h00, 8'h00, 8'h00));
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      obs_v = {data_o, rise_o, fall_o, change_o};
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL filter_reject e=%0d got d=%h r=%h f=%h c=%b want d=%h r=%h f=%h c=%b",
                 e, obs_v[24:17], obs_v[16:9], obs_v[8:1], obs_v[0],
                 exp_v[24:17], exp_v[16:9], exp_v[8:1], exp_v[0]);
      end
      if (e == 3) pin = 8'h00;
    end
  endtask

  // This is a held pulse with T=4. The rise lands at edge 2+4=6. The pin drops
  // after edge 8, so the fall lands at edge 8+6=14.
  task automatic test_filter_accept();
    logic [7:0] d;
    do_reset(8'h01, 16'd4);
    pin = 8'h01;
    for (int e = 1; e <= 16; e++) begin
      d = (e >= 6 && e < 14) ? 8'h01 : 8'h00;
      sb.push_back(mk(d, (e == 6) ? 8'h01 : 8'h00, (e == 14) ? 8'h01 : 8'h00));
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      obs_v = {data_o, rise_o, fall_o, change_o};
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL filter_accept e=%0d got d=%h r=%h f=%h c=%b want d=%h r=%h f=%h c=%b",
                 e, obs_v[24:17], obs_v[16:9], obs_v[8:1], obs_v[0],
                 exp_v[24:17], exp_v[16:9], exp_v[8:1], exp_v[0]);
      end
      if (e == 8) pin = 8'h00;
    end
  endtask

  // Threshold 0 with all filters enabled must behave like bypass. This test
  // also covers multi-bit simultaneous rise and fall.
  task automatic test_thresh_zero();
    logic [7:0] d;
    logic [7:0] r;
    logic [7:0] f;
    do_reset(8'hFF, 16'd0);
    pin = 8'hA5;
    for (int e = 1; e <= 10; e++) begin
      d = (e >= 8) ? 8'h5A : ((e >= 3) ? 8'hA5 : 8'h00);
      r = (e == 3) ? 8'hA5 : ((e == 8) ? 8'h5A : 8'h00);
      f = (e == 8) ? 8'hA5 : 8'h00;
      sb.push_back(mk(d, r, f));
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      obs_v = {data_o, rise_o, fall_o, change_o};
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL thresh_zero e=%0d got d=%h r=%h f=%h c=%b want d=%h r=%h f=%h c=%b",
                 e, obs_v[24:17], obs_v[16:9], obs_v[8:1], obs_v[0],
                 exp_v[24:17], exp_v[16:9], exp_v[8:1], exp_v[0]);
      end
      if (e == 5) pin = 8'h5A;
    end
  endtask

  // Reset is asserted on edge 5, with the counter at 2 of 4. After release
  // with the pin still high, the rise is expected on edge 6.
  task automatic test_reset_midcount();
    do_reset(8'h01, 16'd4);
    pin = 8'h01;
    for (int e = 1; e <= 5; e++) begin
      sb.push_back(mk(8'h00, 8'h00, 8'h00));
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      obs_v = {data_o, rise_o, fall_o, change_o};
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL reset_midcount e=%0d got d=%h r=%h f=%h c=%b want d=%h r=%h f=%h c=%b",
                 e, obs_v[24:17], obs_v[16:9], obs_v[8:1], obs_v[0],
                 exp_v[24:17], exp_v[16:9], exp_v[8:1], exp_v[0]);
      end
      if (e == 4) rst = 1'b1;
    end
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      sb.push_back(mk((e >= 6) ? 8'h01 : 8'h00, (e == 6) ? 8'h01 : 8'h00, 8'h00));
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      obs_v = {data_o, rise_o, fall_o, change_o};
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL reset_release e=%0d got d=%h r=%h f=%h c=%b want d=%h r=%h f=%h c=%b",
                 e, obs_v[24:17], obs_v[16:9], obs_v[8:1], obs_v[0],
                 exp_v[24:17], exp_v[16:9], exp_v[8:1], exp_v[0]);
      end
    end
  endtask

  // Disabling the filter mid-count discards the count: q follows s on the
  // next clock (edge 4).
  task automatic test_filt_toggle();
    do_reset(8'h01, 16'd4);
    pin = 8'h01;
    for (int e = 1; e <= 6; e++) begin
      sb.push_back(mk((e >= 4) ? 8'h01 : 8'h00, (e == 4) ? 8'h01 : 8'h00, 8'h00));
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      obs_v = {data_o, rise_o, fall_o, change_o};
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL filt_toggle e=%0d got d=%h r=%h f=%h c=%b want d=%h r=%h f=%h c=%b",
                 e, obs_v[24:17], obs_v[16:9], obs_v[8:1], obs_v[0],
                 exp_v[24:17], exp_v[16:9], exp_v[8:1], exp_v[0]);
      end
      if (e == 3) filt_en = 8'h00;
    end
  endtask

  // This test alternates 55/AA back to back in bypass mode.
  task automatic test_back_to_back();
    logic [7:0] d;
    logic [7:0] r;
    logic [7:0] f;
    do_reset(8'h00, 16'd0);
    pin = 8'h55;
    for (int e = 1; e <= 13; e++) begin
      d = (e >= 11) ? 8'h55 : ((e >= 7) ? 8'hAA : ((e >= 3) ? 8'h55 : 8'h00));
      r = (e == 3 || e == 11) ? 8'h55 : ((e == 7) ? 8'hAA : 8'h00);
      f = (e == 7) ? 8'h55 : ((e == 11) ? 8'hAA : 8'h00);
      sb.push_back(mk(d, r, f));
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      obs_v = {data_o, rise_o, fall_o, change_o};
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL back_to_back e=%0d got d=%h r=%h f=%h c=%b want d=%h r=%h f=%h c=%b",
                 e, obs_v[24:17], obs_v[16:9], obs_v[8:1], obs_v[0],
                 exp_v[24:17], exp_v[16:9], exp_v[8:1], exp_v[0]);
      end
      if (e == 4) pin = 8'hAA;
      if (e == 8) pin = 8'h55;
    end
  endtask

  initial begin
    rst = 1'b1; pin = 8'h00; filt_en = 8'h00; thr = 16'd0;
    test_reset();
    test_bypass();
    test_filter_reject();
    test_filter_accept();
    test_thresh_zero();
    test_reset_midcount();
    test_filt_toggle();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
